tis_node_core: RTL and testbench

//  Parametrised TIS-100-style compute node: local program RAM, ACC/BAK registers, saturating ALU.

---
 rtl/tis_node_core.sv | 233 +++++++++++++++++++++++
 tb/tb_tis_node_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_node_core.sv
// ============================================================================
// Module   : tis_node_core
// Purpose  : TIS-100-style compute node with program RAM, ACC/BAK, saturating
//            ALU and blocking valid/ack links to four neighbours.
// Options  : TIS_ANY_PORT_EN - src ANY reads the first valid neighbour lane.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tis_node_core #(
  parameter int DATA_W     = 11,
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int SAT_MAX    = 999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [10+DATA_W-1:0]  prog_wdata,
  input  logic [ADDR_W-1:0]     prog_last,
  input  logic [4*DATA_W-1:0]   in_data,
  input  logic [3:0]            in_valid,
  output logic [3:0]            in_ack,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ack,
  output logic [DATA_W-1:0]     acc_dbg,
  output logic [ADDR_W-1:0]     pc_dbg,
  output logic                  stall
);

  localparam int c_iw = 10 + DATA_W;
  localparam int c_jw = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 2;
  localparam logic signed [DATA_W:0] c_sat_pos = (DATA_W+1)'(SAT_MAX);
  localparam logic signed [DATA_W:0] c_sat_neg = (DATA_W+1)'(-SAT_MAX);

  localparam logic [3:0] c_op_mov = 4'd1;
  localparam logic [3:0] c_op_swp = 4'd2;
  localparam logic [3:0] c_op_sav = 4'd3;
  localparam logic [3:0] c_op_add = 4'd4;
  localparam logic [3:0] c_op_sub = 4'd5;
  localparam logic [3:0] c_op_neg = 4'd6;
  localparam logic [3:0] c_op_jmp = 4'd7;
  localparam logic [3:0] c_op_jez = 4'd8;
  localparam logic [3:0] c_op_jnz = 4'd9;
  localparam logic [3:0] c_op_jgz = 4'd10;
  localparam logic [3:0] c_op_jlz = 4'd11;
  localparam logic [3:0] c_op_jro = 4'd12;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_READ_WAIT  = 2'd1,
    S_WRITE_WAIT = 2'd2
  } state_t;

  logic [c_iw-1:0]          r_mem [PROG_DEPTH];
  logic [c_iw-1:0]          r_ir;
  state_t                   r_state, w_state_nxt;
  logic [ADDR_W-1:0]        r_pc, w_pc_nxt;
  logic signed [DATA_W-1:0] r_acc, w_acc_nxt;
  logic signed [DATA_W-1:0] r_bak, w_bak_nxt;
  logic [4*DATA_W-1:0]      r_out_data;
  logic [3:0]               r_out_valid;

  logic [c_iw-1:0]          w_instr;
  logic [3:0]               w_opc;
  logic [2:0]               w_src, w_dst;
  logic signed [DATA_W-1:0] w_imm;
  logic signed [DATA_W-1:0] w_src_val;
  logic                     w_src_port, w_src_ok;
  logic [1:0]               w_src_lane, w_dst_lane;
  logic                     w_dst_port, w_uses_src, w_need_read;
  logic                     w_exec, w_load_out, w_clr_out;
  logic [3:0]               w_in_ack;
  logic [ADDR_W-1:0]        w_pc_inc, w_jmp_tgt, w_jro_tgt;
  logic signed [DATA_W:0]   w_acc_ext, w_src_ext;
  logic signed [c_jw-1:0]   w_jro_sum, w_last_ext;

  function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [DATA_W:0] v);
    if (v > c_sat_pos)      return c_sat_pos[DATA_W-1:0];
    else if (v < c_sat_neg) return c_sat_neg[DATA_W-1:0];
    else                    return v[DATA_W-1:0];
  endfunction

  // Wait states replay the instruction captured at RUN, so RAM writes never disturb a stalled op.
  assign w_instr = (r_state == S_RUN) ? r_mem[r_pc] : r_ir;
  assign w_opc   = w_instr[c_iw-1 -: 4];
  assign w_src   = w_instr[c_iw-5 -: 3];
  assign w_dst   = w_instr[c_iw-8 -: 3];
  assign w_imm   = w_instr[DATA_W-1:0];

  assign w_dst_port  = (w_dst >= 3'd2) && (w_dst <= 3'd5);
  assign w_dst_lane  = 2'(w_dst - 3'd2);
  assign w_uses_src  = (w_opc == c_op_mov) || (w_opc == c_op_add) ||
                       (w_opc == c_op_sub) || (w_opc == c_op_jro);
  assign w_need_read = w_uses_src && w_src_port;

  always_comb begin
    w_src_port = 1'b0;
    w_src_ok   = 1'b1;
    w_src_lane = 2'd0;
    w_src_val  = '0;
    unique case (w_src)
      3'd0: w_src_val = w_imm;
      3'd1: w_src_val = r_acc;
      3'd2: w_src_val = '0;
      3'd7: begin
`ifdef TIS_ANY_PORT_EN
        w_src_port = 1'b1;
        w_src_ok   = |in_valid;
        if (in_valid[0])      w_src_lane = 2'd0;
        else if (in_valid[1]) w_src_lane = 2'd1;
        else if (in_valid[2]) w_src_lane = 2'd2;
        else                  w_src_lane = 2'd3;
`else
        w_src_val = '0;
`endif
      end
      default: begin
        w_src_port = 1'b1;
        w_src_lane = 2'(w_src - 3'd3);
        w_src_ok   = in_valid[w_src_lane];
      end
    endcase
    if (w_src_port) w_src_val = in_data[w_src_lane*DATA_W +: DATA_W];
  end

  assign w_pc_inc   = (r_pc == prog_last) ? '0 : r_pc + 1'b1;
  assign w_jmp_tgt  = (w_imm[ADDR_W-1:0] > prog_last) ? prog_last : w_imm[ADDR_W-1:0];
  assign w_acc_ext  = {r_acc[DATA_W-1], r_acc};
  assign w_src_ext  = {w_src_val[DATA_W-1], w_src_val};
  assign w_jro_sum  = $signed({{(c_jw-ADDR_W){1'b0}}, r_pc}) +
                      $signed({{(c_jw-DATA_W){w_src_val[DATA_W-1]}}, w_src_val});
  assign w_last_ext = $signed({{(c_jw-ADDR_W){1'b0}}, prog_last});
  assign w_jro_tgt  = (w_jro_sum < 0)          ? '0 :
                      (w_jro_sum > w_last_ext) ? prog_last : w_jro_sum[ADDR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_bak_nxt   = r_bak;
    w_in_ack    = '0;
    w_exec      = 1'b0;
    w_load_out  = 1'b0;
    w_clr_out   = 1'b0;
    unique case (r_state)
      S_RUN, S_READ_WAIT: begin
        if (w_need_read && !w_src_ok) begin
          w_state_nxt = S_READ_WAIT;
        end else begin
          if (w_need_read) w_in_ack[w_src_lane] = 1'b1;
          if (w_opc == c_op_mov && w_dst_port) begin
            w_load_out  = 1'b1;
            w_state_nxt = S_WRITE_WAIT;
          end else begin
            w_exec      = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_WRITE_WAIT: begin
        if (out_ack[w_dst_lane]) begin
          w_clr_out   = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase

    if (w_exec) begin
      w_pc_nxt = w_pc_inc;
      case (w_opc)
        c_op_mov: if (w_dst == 3'd0) w_acc_nxt = w_src_val;
        c_op_swp: begin
          w_acc_nxt = r_bak;
          w_bak_nxt = r_acc;
        end
        c_op_sav: w_bak_nxt = r_acc;
        c_op_add: w_acc_nxt = f_sat(w_acc_ext + w_src_ext);
        c_op_sub: w_acc_nxt = f_sat(w_acc_ext - w_src_ext);
        c_op_neg: w_acc_nxt = f_sat(-w_acc_ext);
        c_op_jmp: w_pc_nxt = w_jmp_tgt;
        c_op_jez: if (r_acc == 0) w_pc_nxt = w_jmp_tgt;
        c_op_jnz: if (r_acc != 0) w_pc_nxt = w_jmp_tgt;
        c_op_jgz: if (r_acc > 0)  w_pc_nxt = w_jmp_tgt;
        c_op_jlz: if (r_acc < 0)  w_pc_nxt = w_jmp_tgt;
        c_op_jro: w_pc_nxt = w_jro_tgt;
        default: ;
      endcase
    end
    if (reset) w_in_ack = '0;
  end

  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_pc        <= '0;
      r_acc       <= '0;
      r_bak       <= '0;
      r_ir        <= '0;
      r_out_data  <= '0;
      r_out_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_acc   <= w_acc_nxt;
      r_bak   <= w_bak_nxt;
      if (r_state == S_RUN) r_ir <= w_instr;
      if (w_load_out) begin
        r_out_data[w_dst_lane*DATA_W +: DATA_W] <= w_src_val;
        r_out_valid[w_dst_lane]                 <= 1'b1;
      end
      if (w_clr_out) r_out_valid[w_dst_lane] <= 1'b0;
    end
  end

  assign in_ack    = w_in_ack;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign acc_dbg   = r_acc;
  assign pc_dbg    = r_pc;
  assign stall     = (r_state != S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_tis_node_core.sv
// ============================================================================
// Module   : tb_tis_node_core
// Purpose  : Directed, table-driven self-checking bench for tis_node_core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tis_node_core;

  localparam int DW = 11;
  localparam int AW = 4;
  localparam int IW = 10 + DW;

  localparam int NOP = 0, MOV = 1, SWP = 2, SAV = 3, ADD = 4, SUB = 5, NEG = 6;
  localparam int JMP = 7, JEZ = 8, JNZ = 9, JGZ = 10, JLZ = 11, JRO = 12;
  localparam int S_IMM = 0, S_ACC = 1, S_NIL = 2, S_LEFT = 3, S_ANY = 7;
  localparam int D_ACC = 0, D_NIL = 1, D_RIGHT = 3, D_DOWN = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              prog_we = 1'b0;
  logic [AW-1:0]     prog_addr = '0;
  logic [IW-1:0]     prog_wdata = '0;
  logic [AW-1:0]     prog_last = '0;
  logic [4*DW-1:0]   in_data = '0;
  logic [3:0]        in_valid = '0;
  logic [3:0]        in_ack;
  logic [4*DW-1:0]   out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ack = '0;
  logic [DW-1:0]     acc_dbg;
  logic [AW-1:0]     pc_dbg;
  logic              stall;

  always #5 clk = ~clk;

  tis_node_core #(.DATA_W(DW), .PROG_DEPTH(16), .ADDR_W(AW), .SAT_MAX(999)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_last(prog_last), .in_data(in_data),
    .in_valid(in_valid), .in_ack(in_ack), .out_data(out_data),
    .out_valid(out_valid), .out_ack(out_ack), .acc_dbg(acc_dbg),
    .pc_dbg(pc_dbg), .stall(stall)
  );

  int checks = 0;
  int failures = 0;
  logic [IW-1:0] prog [16];

  typedef struct {
    int opc; int src; int imm; int acc0; int last; int exp_acc; int exp_pc;
  } vec_t;
  vec_t tv[$];

  function automatic logic [IW-1:0] ins(input int opc, input int src, input int dst, input int imm);
    logic [IW-1:0] w;
    w = {opc[3:0], src[2:0], dst[2:0], imm[DW-1:0]};
    return w;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = ins(NOP, 0, 0, 0);
  endtask

  // Holds reset while the whole RAM is rewritten, then releases into RUN at pc 0.
  task automatic load(input int last);
    reset = 1'b1;
    in_valid = '0;
    out_ack = '0;
    tick();
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1;
      prog_addr = AW'(i);
      prog_wdata = prog[i];
      tick();
    end
    prog_we = 1'b0;
    prog_last = AW'(last);
    reset = 1'b0;
  endtask

  function automatic int acc_i();
    return int'($signed(acc_dbg));
  endfunction

  initial begin
    // reset state, with a pending read that must not be acknowledged under reset
    clr_prog();
    prog[0] = ins(MOV, S_LEFT, D_ACC, 0);
    in_valid = 4'b0001;
    reset = 1'b1;
    tick();
    tick();
    in_valid = 4'b0001;
    #1;
    chk("reset_in_ack", int'(in_ack), 0);
    chk("reset_acc", acc_i(), 0);
    chk("reset_pc", int'(pc_dbg), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    in_valid = '0;

    // single-instruction vectors: prog {MOV acc0,ACC; op}
    tv.push_back('{ADD, S_IMM,  998,    5, 5,  999, 2});
    tv.push_back('{ADD, S_IMM,   -5,    3, 5,   -2, 2});
    tv.push_back('{SUB, S_IMM,  500, -600, 5, -999, 2});
    tv.push_back('{SUB, S_IMM,   10,   20, 5,   10, 2});
    tv.push_back('{ADD, S_IMM, -999, -999, 5, -999, 2});
    tv.push_back('{NEG, S_IMM,    0,    7, 5,   -7, 2});
    tv.push_back('{NEG, S_IMM,    0, -999, 5,  999, 2});
    tv.push_back('{SWP, S_IMM,    0,    7, 5,    0, 2});
    tv.push_back('{SAV, S_IMM,    0,    7, 5,    7, 2});
    tv.push_back('{ADD, S_ACC,    0,  300, 5,  600, 2});
    tv.push_back('{ADD, S_NIL,   50,    4, 5,    4, 2});
    tv.push_back('{ADD, S_IMM,    1,    5, 1,    6, 0});
    tv.push_back('{JMP, S_IMM,    4,    1, 5,    1, 4});
    tv.push_back('{JMP, S_IMM,    9,    1, 5,    1, 5});
    tv.push_back('{JEZ, S_IMM,    3,    0, 5,    0, 3});
    tv.push_back('{JEZ, S_IMM,    3,    1, 5,    1, 2});
    tv.push_back('{JNZ, S_IMM,    3,    1, 5,    1, 3});
    tv.push_back('{JNZ, S_IMM,    3,    0, 5,    0, 2});
    tv.push_back('{JGZ, S_IMM,    3,    1, 5,    1, 3});
    tv.push_back('{JGZ, S_IMM,    3,   -1, 5,   -1, 2});
    tv.push_back('{JLZ, S_IMM,    3,   -1, 5,   -1, 3});
    tv.push_back('{JLZ, S_IMM,    3,    0, 5,    0, 2});
    tv.push_back('{JRO, S_IMM,   -5,    0, 5,    0, 0});
    tv.push_back('{JRO, S_IMM,    2,    0, 5,    0, 3});
    tv.push_back('{JRO, S_IMM,   10,    0, 5,    0, 5});
    tv.push_back('{JRO, S_ACC,    0,    2, 5,    2, 3});
    tv.push_back('{13,  S_IMM,  100,    5, 5,    5, 2});
    foreach (tv[k]) begin
      clr_prog();
      prog[0] = ins(MOV, S_IMM, D_ACC, tv[k].acc0);
      prog[1] = ins(tv[k].opc, tv[k].src, D_ACC, tv[k].imm);
      load(tv[k].last);
      tick();
      tick();
      chk($sformatf("vec%0d_acc", k), acc_i(), tv[k].exp_acc);
      chk($sformatf("vec%0d_pc", k), int'(pc_dbg), tv[k].exp_pc);
    end

    // saturating program with wrap, then a same-cycle rewrite of the executing word
    clr_prog();
    prog[0] = ins(MOV, S_IMM, D_ACC, 5);
    prog[1] = ins(ADD, S_IMM, D_ACC, 998);
    prog[2] = ins(NEG, S_IMM, D_ACC, 0);
    load(2);
    tick(); chk("t1_acc0", acc_i(), 5);
    tick(); chk("t1_acc1", acc_i(), 999);
    tick(); chk("t1_acc2", acc_i(), -999);
    chk("t1_wrap_pc", int'(pc_dbg), 0);
    prog_we = 1'b1; prog_addr = '0; prog_wdata = ins(MOV, S_IMM, D_ACC, 9);
    tick();
    prog_we = 1'b0;
    chk("t1_old_word", acc_i(), 5);
    tick(); tick(); tick();
    chk("t1_new_word", acc_i(), 9);

    // read stall on LEFT
    clr_prog();
    prog[0] = ins(MOV, S_LEFT, D_ACC, 0);
    load(1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t2_stall%0d", i), int'(stall), 1);
      chk($sformatf("t2_noack%0d", i), int'(in_ack), 0);
    end
    in_data[0 +: DW] = DW'(42);
    in_valid = 4'b0001;
    #1;
    chk("t2_ack", int'(in_ack), 1);
    tick();
    in_valid = '0;
    #1;
    chk("t2_acc", acc_i(), 42);
    chk("t2_stall_end", int'(stall), 0);
    chk("t2_pc", int'(pc_dbg), 1);
    chk("t2_ack_end", int'(in_ack), 0);

    // write stall on DOWN
    clr_prog();
    prog[0] = ins(MOV, S_IMM, D_DOWN, 7);
    load(1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_valid%0d", i), int'(out_valid), 8);
      chk($sformatf("t3_data%0d", i), int'(out_data[3*DW +: DW]), 7);
      chk($sformatf("t3_pc%0d", i), int'(pc_dbg), 0);
    end
    out_ack = 4'b1000;
    tick();
    out_ack = '0;
    chk("t3_cleared", int'(out_valid), 0);
    chk("t3_pc_adv", int'(pc_dbg), 1);
    chk("t3_stall_end", int'(stall), 0);

    // LEFT -> RIGHT with both sides ready
    clr_prog();
    prog[0] = ins(MOV, S_LEFT, D_RIGHT, 0);
    load(1);
    in_data[0 +: DW] = DW'(33);
    in_valid = 4'b0001;
    #1;
    chk("dd_ack", int'(in_ack), 1);
    tick();
    in_valid = '0;
    chk("dd_valid", int'(out_valid), 2);
    chk("dd_data", int'(out_data[DW +: DW]), 33);
    out_ack = 4'b0010;
    tick();
    out_ack = '0;
    chk("dd_done_valid", int'(out_valid), 0);
    chk("dd_done_pc", int'(pc_dbg), 1);

    // reset while waiting on a write, then rerun the intact program
    clr_prog();
    prog[0] = ins(MOV, S_IMM, D_ACC, 3);
    prog[1] = ins(MOV, S_IMM, D_DOWN, 7);
    load(2);
    tick(); tick(); tick();
    chk("t5_waiting", int'(out_valid), 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_acc", acc_i(), 0);
    chk("t5_pc", int'(pc_dbg), 0);
    tick();
    chk("t5_rerun_acc", acc_i(), 3);
    tick();
    chk("t5_rerun_valid", int'(out_valid), 8);
    out_ack = 4'b1000;
    tick();
    out_ack = '0;
    chk("t5_rerun_pc", int'(pc_dbg), 2);

    // src ANY
    clr_prog();
    prog[0] = ins(MOV, S_ANY, D_ACC, 0);
    prog[1] = ins(MOV, S_IMM, D_ACC, 77);
    prog[2] = ins(MOV, S_ANY, D_ACC, 0);
    load(2);
    in_data[1*DW +: DW] = DW'(11);
    in_data[3*DW +: DW] = DW'(22);
    in_valid = 4'b1010;
    #1;
`ifdef TIS_ANY_PORT_EN
    chk("any_ack", int'(in_ack), 2);
    tick();
    chk("any_acc", acc_i(), 11);
`else
    chk("any_ack", int'(in_ack), 0);
    tick();
    tick();
    chk("any_acc_pre", acc_i(), 77);
    tick();
    chk("any_acc", acc_i(), 0);
    chk("any_nostall", int'(stall), 0);
`endif
    in_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
